hex_word_scroller: RTL

- Parametrised successor to the single-digit 3-bit character decoder.
- Holds a message of MSG_LEN 3-bit character codes in a circular buffer and shows a NUM_DIGITS-wide window on the HEX displays.
- Scrolls the window one position every TICK_DIV clocks, left or right.
- Sits between the switch/key input logic and the board HEX outputs.

---
 rtl/hex_word_scroller.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hex_word_scroller.sv
// hex_word_scroller: circular buffer of 3-bit character codes shown as a scrolling window on 7-segment digits.
// Optional blink gating is compiled in with `define HEX_WORD_SCROLLER_BLINK_EN.
module hex_word_scroller #(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 8,
  parameter int TICK_DIV   = 50000000
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic                    wr_valid,
  input  logic [2:0]              wr_char,
  output logic                    wr_ready,
  input  logic                    run,
  input  logic                    dir,
  input  logic                    clr,
  input  logic                    blink,
  output logic                    tick_o,
  output logic [7*NUM_DIGITS-1:0] HEX
);

  localparam int PW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PTR_LAST = PW'(MSG_LEN - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [PW:0]   IDX_WRAP = (PW+1)'(MSG_LEN);
  localparam logic [2:0]    CH_BLANK = 3'b111;

  function automatic logic [6:0] seg_decode(input logic [2:0] code);
    logic [6:0] seg;
    case (code)
      3'b000:  seg = 7'h09;
      3'b001:  seg = 7'h06;
      3'b010:  seg = 7'h47;
      3'b011:  seg = 7'h40;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [2:0]              r_msg [MSG_LEN];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_off;
  logic [CW-1:0]           r_presc;
  logic                    r_tick;
  logic [7*NUM_DIGITS-1:0] r_hex;
  logic                    w_tick;
  logic                    w_wr_en;
  logic [PW:0]             w_idx;
  logic [7*NUM_DIGITS-1:0] w_hex;

  assign wr_ready = ~run & ~clr;
  assign w_wr_en  = wr_valid & wr_ready;
  assign w_tick   = run & (r_presc == CNT_LAST);
  assign tick_o   = r_tick;
  assign HEX      = r_hex;

  // Message buffer storage.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MSG_LEN; i++) r_msg[i] <= CH_BLANK;
    end else if (clr) begin
      for (int i = 0; i < MSG_LEN; i++) r_msg[i] <= CH_BLANK;
    end else if (w_wr_en) begin
      r_msg[r_wr_ptr] <= wr_char;
    end
  end

  // Write pointer, prescaler, window offset and tick pulse.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= {PW{1'b0}};
      r_off    <= {PW{1'b0}};
      r_presc  <= {CW{1'b0}};
      r_tick   <= 1'b0;
    end else if (clr) begin
      r_wr_ptr <= {PW{1'b0}};
      r_off    <= {PW{1'b0}};
      r_presc  <= {CW{1'b0}};
      r_tick   <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? {PW{1'b0}} : r_wr_ptr + PW'(1);
      end
      if (!run || w_tick) begin
        r_presc <= {CW{1'b0}};
      end else begin
        r_presc <= r_presc + CW'(1);
      end
      if (w_tick) begin
        if (dir) begin
          r_off <= (r_off == {PW{1'b0}}) ? PTR_LAST : r_off - PW'(1);
        end else begin
          r_off <= (r_off == PTR_LAST) ? {PW{1'b0}} : r_off + PW'(1);
        end
      end
      r_tick <= w_tick;
    end
  end

`ifdef HEX_WORD_SCROLLER_BLINK_EN
  logic r_phase;

  // Blink phase advances once per scroll step.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_phase <= 1'b0;
    end else if (clr) begin
      r_phase <= 1'b0;
    end else if (w_tick) begin
      r_phase <= ~r_phase;
    end
  end
`else
  logic w_unused_blink;
  assign w_unused_blink = blink;
`endif

  // Window decode: leftmost digit shows msg[off], index wraps at MSG_LEN.
  always_comb begin
    w_hex = {(7*NUM_DIGITS){1'b1}};
    w_idx = {(PW+1){1'b0}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_idx = {1'b0, r_off} + (PW+1)'(NUM_DIGITS - 1 - k);
      if (w_idx >= IDX_WRAP) begin
        w_idx = w_idx - IDX_WRAP;
      end else begin
        w_idx = w_idx;
      end
      w_hex[7*k +: 7] = seg_decode(r_msg[w_idx[PW-1:0]]);
    end
`ifdef HEX_WORD_SCROLLER_BLINK_EN
    if (blink && r_phase) begin
      w_hex = {(7*NUM_DIGITS){1'b1}};
    end else begin
      w_hex = w_hex;
    end
`endif
  end

  // Registered segment outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_hex <= {(7*NUM_DIGITS){1'b1}};
    end else begin
      r_hex <= w_hex;
    end
  end

endmodule
